// File: rtl/fft_pkg.sv
// fft_pkg: definitions shared by the FFT sequencer, butterfly and twiddle ROM.
//   fft_state_e  : sequencer FSM states
//   clog2        : ceil(log2(v)), usable in parameter expressions
//   DEF_N_POINTS : default transform length
//   DEF_PIPE_LAT : default read-to-write-back latency
package fft_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fft_state_e;

    localparam int unsigned DEF_N_POINTS = 64;
    localparam int unsigned DEF_PIPE_LAT = 2;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned p;
        r = 0;
        p = 1;
        while (p < v) begin
            p = p << 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_stage_sequencer_if.sv
// fft_stage_sequencer_if: control and memory-side signals of the FFT stage
// sequencer.
//   master : the sequencer (takes start_i, drives status, read and write-back strobes/addresses)
//   slave  : the environment (drives start_i, observes everything else)
interface fft_stage_sequencer_if #(
    parameter int unsigned LOG2N  = 6,
    parameter int unsigned ADDR_W = LOG2N
);
    logic                start_i;
    logic                busy_o;
    logic                done_o;
    logic [LOG2N-1:0]    stage_o;
    logic                rd_en_o;
    logic [ADDR_W-1:0]   rd_addr_a_o;
    logic [ADDR_W-1:0]   rd_addr_b_o;
    logic [LOG2N-2:0]    tw_addr_o;
    logic                wr_en_o;
    logic [ADDR_W-1:0]   wr_addr_a_o;
    logic [ADDR_W-1:0]   wr_addr_b_o;

    modport master (
        input  start_i,
        output busy_o, done_o, stage_o,
        output rd_en_o, rd_addr_a_o, rd_addr_b_o, tw_addr_o,
        output wr_en_o, wr_addr_a_o, wr_addr_b_o
    );

    modport slave (
        output start_i,
        input  busy_o, done_o, stage_o,
        input  rd_en_o, rd_addr_a_o, rd_addr_b_o, tw_addr_o,
        input  wr_en_o, wr_addr_a_o, wr_addr_b_o
    );
endinterface

// File: rtl/fft_addr_gen.sv
// fft_addr_gen: combinational radix-2 DIT butterfly address map.
//   s_i      : stage index
//   k_i      : butterfly index within the stage, 0..N/2-1
//   addr_a_o : upper operand address
//   addr_b_o : lower operand address (addr_a_o + 2^s)
//   tw_o     : twiddle ROM index
module fft_addr_gen #(
    parameter int unsigned LOG2N  = 6,
    parameter int unsigned ADDR_W = LOG2N
) (
    input  logic [LOG2N-1:0]  s_i,
    input  logic [LOG2N-2:0]  k_i,
    output logic [ADDR_W-1:0] addr_a_o,
    output logic [ADDR_W-1:0] addr_b_o,
    output logic [LOG2N-2:0]  tw_o
);
    localparam int unsigned TW_W = LOG2N - 1;

    logic [ADDR_W-1:0] k_ext;
    logic [ADDR_W-1:0] half;
    logic [ADDR_W-1:0] pos;
    logic [ADDR_W-1:0] group;
    logic [LOG2N-1:0]  tw_sh;

    always_comb begin
        k_ext    = ADDR_W'(k_i);
        half     = ADDR_W'(1) << s_i;
        pos      = k_ext & (half - ADDR_W'(1));
        group    = k_ext >> s_i;
        addr_a_o = (group << (s_i + LOG2N'(1))) | pos;
        addr_b_o = addr_a_o + half;
        tw_sh    = LOG2N'(LOG2N - 1) - s_i;
        // pos < 2^s, so the shifted index always fits in LOG2N-1 bits
        tw_o     = TW_W'(pos << tw_sh);
    end
endmodule

// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: drives one shared butterfly over all log2(N) stages of
// an in-place radix-2 DIT FFT. Issues one read pair + twiddle index per cycle,
// replays the pair as a write-back PIPE_LAT cycles later, and idles PIPE_LAT
// drain cycles between stages so no stage reads unwritten data.
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-high reset
//   bus   : start/busy/done control, read and write-back strobes/addresses
module fft_stage_sequencer
    import fft_pkg::*;
#(
    parameter int unsigned N_POINTS = DEF_N_POINTS,
    parameter int unsigned LOG2N    = clog2(N_POINTS),
    parameter int unsigned ADDR_W   = LOG2N,
    parameter int unsigned PIPE_LAT = DEF_PIPE_LAT
) (
    input logic                   clk_i,
    input logic                   rst_i,
    fft_stage_sequencer_if.master bus
);
    localparam int unsigned K_W   = LOG2N - 1;
    localparam int unsigned TW_W  = LOG2N - 1;
    localparam int unsigned CNT_W = clog2(PIPE_LAT + 1);

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] a;
        logic [ADDR_W-1:0] b;
    } wb_t;

    fft_state_e        state_q, state_d;
    logic [LOG2N-1:0]  stage_q, stage_d;
    logic [K_W-1:0]    k_q, k_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_a_q, rd_a_d;
    logic [ADDR_W-1:0] rd_b_q, rd_b_d;
    logic [TW_W-1:0]   tw_q, tw_d;
    wb_t               pipe_q [PIPE_LAT];
    wb_t               pipe_d [PIPE_LAT];

    logic [ADDR_W-1:0] gen_a;
    logic [ADDR_W-1:0] gen_b;
    logic [TW_W-1:0]   gen_tw;

    fft_addr_gen #(
        .LOG2N  (LOG2N),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .s_i      (stage_q),
        .k_i      (k_q),
        .addr_a_o (gen_a),
        .addr_b_o (gen_b),
        .tw_o     (gen_tw)
    );

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        rd_en_d = 1'b0;
        rd_a_d  = '0;
        rd_b_d  = '0;
        tw_d    = '0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    state_d = ST_RUN;
                    stage_d = '0;
                    k_d     = '0;
                end
            end
            ST_RUN: begin
                busy_d  = 1'b1;
                rd_en_d = 1'b1;
                rd_a_d  = gen_a;
                rd_b_d  = gen_b;
                tw_d    = gen_tw;
                if (k_q == '1) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end
            ST_DRAIN: begin
                busy_d = 1'b1;
                if (cnt_q == CNT_W'(PIPE_LAT - 1)) begin
                    if (stage_q == LOG2N'(LOG2N - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                        stage_d = stage_q + LOG2N'(1);
                        k_d     = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
                stage_d = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Write-back delay line: head is fed from the registered read outputs,
    // so the tail lines up exactly PIPE_LAT cycles behind rd_*.
    always_comb begin
        pipe_d[0] = '{valid: rd_en_q, a: rd_a_q, b: rd_b_q};
        for (int unsigned i = 1; i < PIPE_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            stage_q <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
            rd_a_q  <= '0;
            rd_b_q  <= '0;
            tw_q    <= '0;
            for (int unsigned i = 0; i < PIPE_LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rd_en_q <= rd_en_d;
            rd_a_q  <= rd_a_d;
            rd_b_q  <= rd_b_d;
            tw_q    <= tw_d;
            for (int unsigned i = 0; i < PIPE_LAT; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;
    assign bus.stage_o     = stage_q;
    assign bus.rd_en_o     = rd_en_q;
    assign bus.rd_addr_a_o = rd_a_q;
    assign bus.rd_addr_b_o = rd_b_q;
    assign bus.tw_addr_o   = tw_q;
    assign bus.wr_en_o     = pipe_q[PIPE_LAT-1].valid;
    assign bus.wr_addr_a_o = pipe_q[PIPE_LAT-1].a;
    assign bus.wr_addr_b_o = pipe_q[PIPE_LAT-1].b;
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb_fft_stage_sequencer: directed bench for fft_stage_sequencer.
// An N=8/PIPE_LAT=2 instance is checked cycle by cycle against hand tables;
// an N=64/PIPE_LAT=1 instance is checked against fft_addr_gen plus a
// per-stage write-coverage bitmap.
module tb_fft_stage_sequencer;
    import fft_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    fft_stage_sequencer_if #(.LOG2N(3), .ADDR_W(3)) bus8 ();
    fft_stage_sequencer_if #(.LOG2N(6), .ADDR_W(6)) bus64 ();

    fft_stage_sequencer #(.N_POINTS(8), .PIPE_LAT(2)) dut8 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus8.master)
    );

    fft_stage_sequencer #(.N_POINTS(64), .PIPE_LAT(1)) dut64 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus64.master)
    );

    logic [5:0] m_s;
    logic [4:0] m_k;
    logic [5:0] m_a, m_b;
    logic [4:0] m_tw;

    fft_addr_gen #(.LOG2N(6), .ADDR_W(6)) ref_gen (
        .s_i      (m_s),
        .k_i      (m_k),
        .addr_a_o (m_a),
        .addr_b_o (m_b),
        .tw_o     (m_tw)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Hand-computed N=8 read schedule, indexed stage*4 + k.
    int unsigned ea8 [12] = '{0, 2, 4, 6,  0, 1, 4, 5,  0, 1, 2, 3};
    int unsigned eb8 [12] = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
    int unsigned et8 [12] = '{0, 0, 0, 0,  0, 2, 0, 2,  0, 1, 2, 3};

    // Expected N=8 read for cycle c (stage period 4 reads + 2 drain).
    task automatic exp_read8(input int c, output bit en, output int unsigned idx);
        int s, j;
        en  = 1'b0;
        idx = 0;
        if (c >= 1) begin
            s = (c - 1) / 6;
            j = (c - 1) % 6;
            if (s < 3 && j < 4) begin
                en  = 1'b1;
                idx = s * 4 + j;
            end
        end
    endtask

    task automatic check_idle8(input string tag);
        check_eq({tag, "_busy"},  bus8.busy_o, 0);
        check_eq({tag, "_done"},  bus8.done_o, 0);
        check_eq({tag, "_stage"}, bus8.stage_o, 0);
        check_eq({tag, "_rd_en"}, bus8.rd_en_o, 0);
        check_eq({tag, "_rd_a"},  bus8.rd_addr_a_o, 0);
        check_eq({tag, "_rd_b"},  bus8.rd_addr_b_o, 0);
        check_eq({tag, "_tw"},    bus8.tw_addr_o, 0);
        check_eq({tag, "_wr_en"}, bus8.wr_en_o, 0);
        check_eq({tag, "_wr_a"},  bus8.wr_addr_a_o, 0);
        check_eq({tag, "_wr_b"},  bus8.wr_addr_b_o, 0);
    endtask

    // One N=8 transform; hold keeps start_i high through the done cycle.
    task automatic run8(input string tag, input bit hold);
        bit          ren, wen;
        int unsigned ri, wi;
        int unsigned dones;
        dones = 0;
        @(negedge clk);
        bus8.start_i = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) bus8.start_i = 1'b0;
        for (int c = 1; c <= 23; c++) begin
            @(posedge clk);
            #1;
            exp_read8(c, ren, ri);
            exp_read8(c - 2, wen, wi);
            check_eq($sformatf("%s_c%0d_rd_en", tag, c), bus8.rd_en_o, ren);
            check_eq($sformatf("%s_c%0d_rd_a", tag, c), bus8.rd_addr_a_o, ren ? ea8[ri] : 0);
            check_eq($sformatf("%s_c%0d_rd_b", tag, c), bus8.rd_addr_b_o, ren ? eb8[ri] : 0);
            check_eq($sformatf("%s_c%0d_tw", tag, c), bus8.tw_addr_o, ren ? et8[ri] : 0);
            if (ren) check_eq($sformatf("%s_c%0d_stage", tag, c), bus8.stage_o, ri / 4);
            check_eq($sformatf("%s_c%0d_wr_en", tag, c), bus8.wr_en_o, wen);
            check_eq($sformatf("%s_c%0d_wr_a", tag, c), bus8.wr_addr_a_o, wen ? ea8[wi] : 0);
            check_eq($sformatf("%s_c%0d_wr_b", tag, c), bus8.wr_addr_b_o, wen ? eb8[wi] : 0);
            check_eq($sformatf("%s_c%0d_busy", tag, c), bus8.busy_o, (c <= 18) ? 1 : 0);
            check_eq($sformatf("%s_c%0d_done", tag, c), bus8.done_o, (c == 19) ? 1 : 0);
            if (bus8.done_o === 1'b1) dones++;
            if (hold && c == 19) bus8.start_i = 1'b0;
        end
        check_eq({tag, "_done_count"}, dones, 1);
    endtask

    int unsigned hist_en [0:255];
    int unsigned hist_a  [0:255];
    int unsigned hist_b  [0:255];
    int unsigned hist_s  [0:255];
    int unsigned written [6][64];

    task automatic run64(input string tag);
        int s, j;
        bit ren;
        int unsigned once;
        for (int i = 0; i < 6; i++)
            for (int a = 0; a < 64; a++) written[i][a] = 0;
        @(negedge clk);
        bus64.start_i = 1'b1;
        @(posedge clk);
        #1;
        bus64.start_i = 1'b0;
        hist_en[0] = 0;
        for (int c = 1; c <= 201; c++) begin
            @(posedge clk);
            #1;
            s   = (c - 1) / 33;
            j   = (c - 1) % 33;
            ren = (s < 6 && j < 32);
            m_s = ren ? 6'(s) : '0;
            m_k = ren ? 5'(j) : '0;
            #1;
            hist_en[c] = ren;
            hist_a[c]  = ren ? 32'(m_a) : 0;
            hist_b[c]  = ren ? 32'(m_b) : 0;
            hist_s[c]  = ren ? s : 0;
            check_eq($sformatf("%s_c%0d_rd_en", tag, c), bus64.rd_en_o, ren);
            check_eq($sformatf("%s_c%0d_rd_a", tag, c), bus64.rd_addr_a_o, hist_a[c]);
            check_eq($sformatf("%s_c%0d_rd_b", tag, c), bus64.rd_addr_b_o, hist_b[c]);
            check_eq($sformatf("%s_c%0d_tw", tag, c), bus64.tw_addr_o, ren ? 32'(m_tw) : 0);
            check_eq($sformatf("%s_c%0d_wr_en", tag, c), bus64.wr_en_o, hist_en[c-1]);
            check_eq($sformatf("%s_c%0d_wr_a", tag, c), bus64.wr_addr_a_o, hist_a[c-1]);
            check_eq($sformatf("%s_c%0d_wr_b", tag, c), bus64.wr_addr_b_o, hist_b[c-1]);
            check_eq($sformatf("%s_c%0d_done", tag, c), bus64.done_o, (c == 199) ? 1 : 0);
            check_eq($sformatf("%s_c%0d_busy", tag, c), bus64.busy_o, (c <= 198) ? 1 : 0);
            if (bus64.wr_en_o === 1'b1 && hist_en[c-1] != 0) begin
                written[hist_s[c-1]][bus64.wr_addr_a_o]++;
                written[hist_s[c-1]][bus64.wr_addr_b_o]++;
            end
        end
        for (int i = 0; i < 6; i++) begin
            once = 0;
            for (int a = 0; a < 64; a++) if (written[i][a] == 1) once++;
            check_eq($sformatf("%s_stage%0d_cover", tag, i), once, 64);
        end
    endtask

    initial begin
        bus8.start_i  = 1'b0;
        bus64.start_i = 1'b0;
        m_s = '0;
        m_k = '0;

        // Reset held, start pulsed: nothing may happen.
        repeat (2) @(posedge clk);
        #1;
        check_idle8("rst");
        @(negedge clk);
        bus8.start_i = 1'b1;
        @(posedge clk);
        #1;
        bus8.start_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle8("rst_start");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle8("idle");
        check_eq("idle64_busy", bus64.busy_o, 0);
        check_eq("idle64_rd_en", bus64.rd_en_o, 0);

        run8("n8a", 1'b0);
        run8("n8hold", 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check_idle8("after_hold");

        // Reset mid-transform in cycle 8; stage-1 writes in flight must vanish.
        @(negedge clk);
        bus8.start_i = 1'b1;
        @(posedge clk);
        #1;
        bus8.start_i = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check_eq("mid_busy_pre", bus8.busy_o, 1);
        check_eq("mid_rd_en_pre", bus8.rd_en_o, 1);
        #1;
        rst = 1'b1;
        #1;
        check_eq("mid_busy_post", bus8.busy_o, 0);
        check_eq("mid_rd_en_post", bus8.rd_en_o, 0);
        check_eq("mid_wr_en_post", bus8.wr_en_o, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check_idle8($sformatf("post_rst%0d", i));
        end

        run8("n8b", 1'b0);

        // Back-to-back N=64 transforms with a random idle gap.
        run64("n64a");
        repeat ($urandom_range(0, 2)) @(posedge clk);
        run64("n64b");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fft_stage_sequencer.md
# fft_stage_sequencer

Control sequencer for the in-place radix-2 DIT FFT engine. It sequences one shared combinational butterfly over all log2(N) stages. For each butterfly it issues A/B read addresses and a twiddle-ROM index. It then issues the matching write-back addresses after a fixed pipeline latency, and inserts drain cycles between stages so no stage reads data the previous stage has not yet written. It sits between the start/done control interface and the sample RAM, twiddle ROM and butterfly datapath. Input bit-reversal is the loader's job, not this block's.

## Interface
- N_POINTS, 64, transform length; power of two, ≥4
- LOG2N, 6, log2(N_POINTS)
- ADDR_W, LOG2N, sample RAM address width
- PIPE_LAT, 2, cycles from read-address issue to write-back of that butterfly (RAM read + butterfly register); ≥1

- clk_i  in  1  clock; all logic on the rising edge
- rst_i  in  1  asynchronous, active-high reset
- start_i  in  1  begin a transform; sampled only in IDLE
- busy_o  out  1  high from the cycle after start is accepted until done_o
- done_o  out  1  one-cycle pulse after the final write-back
- stage_o  out  LOG2N bits  current stage index (valid while busy_o)
- rd_en_o  out  1  read strobe for the sample RAM
- rd_addr_a_o, rd_addr_b_o  out  ADDR_W each  butterfly operand addresses
- tw_addr_o  out  LOG2N-1  twiddle ROM index, aligned with rd_en_o
- wr_en_o  out  1  write-back strobe
- wr_addr_a_o, wr_addr_b_o  out  ADDR_W each  write-back addresses

## Operation
- FSM states and transitions:
  - IDLE: start_i=1 → RUN. start_i=0 stays in IDLE.
  - RUN: one butterfly per cycle, k = 0..N/2-1. At k = N/2-1 → DRAIN.
  - DRAIN: PIPE_LAT cycles, no reads. Then → RUN with stage+1, or → DONE if the final stage has completed.
  - DONE: one cycle, then → IDLE.
- start_i outside IDLE is ignored.
- Address math for stage s and butterfly k (half = 1<<s):
  - group = k>>s
  - pos = k & (half-1)
  - addr_a = (group<<(s+1)) | pos
  - addr_b = addr_a + half
  - tw = pos<<(LOG2N-1-s)
  - All values are unsigned. No result ever exceeds its port width.
- Write-back uses a PIPE_LAT-deep shift register of {valid, addr_a, addr_b}. wr_* are the delayed copies of rd_*; wr_en_o is the delayed rd_en_o.
- Outputs are registered. While rd_en_o/wr_en_o are low, all address outputs are held at 0.
- Reset values: busy_o=0, done_o=0, stage_o=0, rd_en_o=0, wr_en_o=0, all addresses 0, state IDLE.
- Reset mid-transform: all in-flight writes are discarded and the FSM returns to IDLE. No done_o is produced.

## Timing
- The start_i sampling edge is cycle 0.
- Stage s issues reads in cycles 1 + s·(N/2+PIPE_LAT) through s·(N/2+PIPE_LAT) + N/2.
- The write for a read in cycle t occurs in cycle t+PIPE_LAT.
- The next stage's first read occurs exactly one cycle after the previous stage's last write. A read and a write never target the same address in the same cycle.
- done_o is high in cycle LOG2N·(N/2+PIPE_LAT)+1. busy_o falls in that same cycle.
- A new start_i may be accepted in the cycle after done_o.

## Structure
- Shared package fft_pkg holds:
  - FSM state encodings (IDLE, RUN, DRAIN, DONE)
  - the clog2 helper
  - the default N_POINTS/PIPE_LAT constants shared with the butterfly and twiddle ROM
- One natural sub-module, fft_addr_gen: a purely combinational map from (s, k) to (addr_a, addr_b, tw). It is reused by the bench's reference model.
- The delay line and FSM live in the top module.

## Test plan
- Reset, then idle: all outputs 0. start_i pulse with rst_i=1 → no activity.
- N=8, PIPE_LAT=2, single start, read sequence:
  - stage 0: pairs (0,1),(2,3),(4,5),(6,7), tw 0,0,0,0
  - stage 1: pairs (0,2),(1,3),(4,6),(5,7), tw 0,2,0,2
  - stage 2: pairs (0,4),(1,5),(2,6),(3,7), tw 0,1,2,3
  - done_o high exactly in cycle 19
- Write alignment (N=8, PIPE_LAT=2): every wr_* equals rd_* from 2 cycles earlier. No read in cycles 5–6 or 11–12. Each stage's first read follows its predecessor's last write by one cycle.
- start_i held high for the whole transform → exactly one transform and one done_o. The next transform starts only when start_i is high in IDLE after done_o.
- rst_i asserted in cycle 8 of an N=8 run → wr_en_o and busy_o drop immediately (asynchronous reset). A fresh start afterwards produces the full cycle-19 sequence again.
- N=64, PIPE_LAT=1, random back-to-back starts: scoreboard via fft_addr_gen; each stage writes every address exactly once and done_o is at cycle 6·33+1=199.
